// File: rtl/async_fifo_rd_packer_if.sv
// async_fifo_rd_packer_if: FIFO read port plus packed valid/ready output stream.
// Rev 1.0
`default_nettype none

interface async_fifo_rd_packer_if #(
  parameter int DWIDTH = 8,
  parameter int RATIO  = 4
);
  logic                      pop;
  logic                      empty;
  logic [DWIDTH-1:0]         rddata;
  logic                      flush;
  logic                      out_valid;
  logic                      out_ready;
  logic [DWIDTH*RATIO-1:0]   out_data;
  logic [RATIO-1:0]          out_keep;

  modport master (
    output pop,
    input  empty,
    input  rddata,
    input  flush,
    output out_valid,
    input  out_ready,
    output out_data,
    output out_keep
  );

  modport slave (
    input  pop,
    output empty,
    output rddata,
    output flush,
    input  out_valid,
    output out_ready,
    input  out_data,
    input  out_keep
  );
endinterface

`default_nettype wire

// File: rtl/async_fifo_rd_packer.sv
// async_fifo_rd_packer: pops RATIO FIFO words, packs them, emits via a 2-entry output buffer.
// Rev 1.0
`default_nettype none

module async_fifo_rd_packer #(
  parameter int DWIDTH = 8,
  parameter int RATIO  = 4
) (
  input  logic                    rdclk_i,
  input  logic                    reset_i,
  async_fifo_rd_packer_if.master  bus
);

  localparam int              LW   = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int              PW   = DWIDTH * RATIO;
  localparam logic [LW-1:0]   LAST = LW'(RATIO - 1);

  logic [LW-1:0]    lane_q, lane_d;
  logic             inflight_q;
  logic             flush_pend_q, flush_pend_d;
  logic [PW-1:0]    pack_q, pack_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [PW-1:0]    ob0_data_q, ob0_data_d, ob1_data_q, ob1_data_d;
  logic [RATIO-1:0] ob0_keep_q, ob0_keep_d, ob1_keep_q, ob1_keep_d;

  logic             deq, enq, pop, slot_ok, infl_cmp, iss_cmp, free;
  logic [LW-1:0]    lane_ret, issue_lane;
  logic [2:0]       cnt_eff;
  logic [PW-1:0]    enq_data, part_mask;
  logic [RATIO-1:0] enq_keep, part_keep;

  always_comb begin
    deq        = (cnt_q != 2'd0) && bus.out_ready;
    lane_ret   = (lane_q == LAST) ? '0 : lane_q + LW'(1);
    infl_cmp   = inflight_q && (lane_q == LAST);
    issue_lane = inflight_q ? lane_ret : lane_q;
    iss_cmp    = (issue_lane == LAST);
    // Projected buffer occupancy if this pop is issued, counting words already in flight.
    cnt_eff    = 3'(cnt_q) - 3'(deq) + 3'(infl_cmp) + 3'(iss_cmp);
    slot_ok    = (cnt_eff <= 3'd2);
    pop        = !reset_i && !bus.empty && !flush_pend_q && !bus.flush && slot_ok;
    free       = (cnt_q != 2'd2) || deq;

    part_keep = '0;
    part_mask = '0;
    for (int i = 0; i < RATIO; i++) begin
      part_keep[i]                 = (i < int'(lane_q));
      part_mask[i*DWIDTH +: DWIDTH] = {DWIDTH{part_keep[i]}};
    end

    pack_d       = pack_q;
    lane_d       = lane_q;
    enq          = 1'b0;
    enq_data     = '0;
    enq_keep     = '0;
    flush_pend_d = flush_pend_q | bus.flush;

    if (inflight_q) begin
      pack_d[int'(lane_q)*DWIDTH +: DWIDTH] = bus.rddata;
      lane_d = lane_ret;
      if (lane_q == LAST) begin
        enq      = 1'b1;
        enq_data = pack_d;
        enq_keep = '1;
      end
    end

    // Pops are blocked while pending, so no return can collide with the partial enqueue.
    if (flush_pend_q && !inflight_q && free) begin
      flush_pend_d = 1'b0;
      if (lane_q != '0) begin
        enq      = 1'b1;
        enq_data = pack_q & part_mask;
        enq_keep = part_keep;
        lane_d   = '0;
      end
    end

    ob0_data_d = ob0_data_q;
    ob0_keep_d = ob0_keep_q;
    ob1_data_d = ob1_data_q;
    ob1_keep_d = ob1_keep_q;
    if (deq) begin
      ob0_data_d = ob1_data_q;
      ob0_keep_d = ob1_keep_q;
    end
    if (enq) begin
      if ((cnt_q == 2'd0) || ((cnt_q == 2'd1) && deq)) begin
        ob0_data_d = enq_data;
        ob0_keep_d = enq_keep;
      end else begin
        ob1_data_d = enq_data;
        ob1_keep_d = enq_keep;
      end
    end
    cnt_d = cnt_q + 2'(enq) - 2'(deq);
  end

  always_ff @(posedge rdclk_i) begin
    if (reset_i) begin
      lane_q       <= '0;
      inflight_q   <= 1'b0;
      flush_pend_q <= 1'b0;
      pack_q       <= '0;
      cnt_q        <= 2'd0;
      ob0_data_q   <= '0;
      ob0_keep_q   <= '0;
      ob1_data_q   <= '0;
      ob1_keep_q   <= '0;
    end else begin
      lane_q       <= lane_d;
      inflight_q   <= pop;
      flush_pend_q <= flush_pend_d;
      pack_q       <= pack_d;
      cnt_q        <= cnt_d;
      ob0_data_q   <= ob0_data_d;
      ob0_keep_q   <= ob0_keep_d;
      ob1_data_q   <= ob1_data_d;
      ob1_keep_q   <= ob1_keep_d;
    end
  end

  assign bus.pop       = pop;
  assign bus.out_valid = (cnt_q != 2'd0);
  assign bus.out_data  = ob0_data_q;
  assign bus.out_keep  = ob0_keep_q;

endmodule

`default_nettype wire

// File: tb/tb_async_fifo_rd_packer.sv
// tb_async_fifo_rd_packer: directed vectors for the read-side packer (RATIO=4 and RATIO=1).
// Rev 1.0
`default_nettype none
`timescale 1ns/1ps

module tb_async_fifo_rd_packer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  async_fifo_rd_packer_if #(.DWIDTH(8), .RATIO(4)) bus ();
  async_fifo_rd_packer_if #(.DWIDTH(8), .RATIO(1)) bus1 ();

  async_fifo_rd_packer #(.DWIDTH(8), .RATIO(4)) u_dut (
    .rdclk_i (clk),
    .reset_i (rst),
    .bus     (bus.master)
  );

  async_fifo_rd_packer #(.DWIDTH(8), .RATIO(1)) u_dut1 (
    .rdclk_i (clk),
    .reset_i (rst),
    .bus     (bus1.master)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // FIFO model with registered read; reset empties it.
  logic [7:0] mem [0:255];
  int         wr_ptr = 0;
  int         rd_ptr = 0;
  logic       empty_force = 1'b0;

  assign bus.empty = (wr_ptr == rd_ptr) || empty_force;

  task automatic push(input logic [7:0] v);
    mem[wr_ptr % 256] = v;
    wr_ptr = wr_ptr + 1;
  endtask

  always @(posedge clk) begin
    if (rst) rd_ptr <= wr_ptr;
    else if (bus.pop) begin
      bus.rddata <= mem[rd_ptr % 256];
      rd_ptr     <= rd_ptr + 1;
    end
  end

  // Monitors and scoreboard capture.
  int          pop_total = 0, cur_run = 0, last_run = 0, rx_n = 0, pe_viol = 0, stab_viol = 0;
  logic [31:0] rx_data [0:63];
  logic [3:0]  rx_keep [0:63];
  logic        hold_q = 1'b0;
  logic [31:0] hold_d = '0;
  logic [3:0]  hold_k = '0;

  always @(posedge clk) begin
    if (bus.pop && bus.empty) pe_viol <= pe_viol + 1;
    if (bus.pop) begin
      pop_total <= pop_total + 1;
      cur_run   <= cur_run + 1;
    end else begin
      if (cur_run != 0) last_run <= cur_run;
      cur_run <= 0;
    end
    if (!rst && bus.out_valid && bus.out_ready && rx_n < 64) begin
      rx_data[rx_n] <= bus.out_data;
      rx_keep[rx_n] <= bus.out_keep;
      rx_n          <= rx_n + 1;
    end
    if (hold_q && !rst && (!bus.out_valid || bus.out_data !== hold_d || bus.out_keep !== hold_k))
      stab_viol <= stab_viol + 1;
    hold_q <= !rst && bus.out_valid && !bus.out_ready;
    hold_d <= bus.out_data;
    hold_k <= bus.out_keep;
  end

  // RATIO=1 instance: counting source, always ready.
  logic en1 = 1'b0;
  int   rd_cnt1 = 0, n1 = 0, bad1 = 0, exp1 = 0, run1 = 0, max1 = 0;

  assign bus1.empty     = !en1;
  assign bus1.flush     = 1'b0;
  assign bus1.out_ready = 1'b1;

  always @(posedge clk) begin
    if (!rst && bus1.pop) begin
      bus1.rddata <= 8'(rd_cnt1);
      rd_cnt1     <= rd_cnt1 + 1;
    end
    if (!rst && bus1.out_valid) begin
      n1   <= n1 + 1;
      exp1 <= exp1 + 1;
      if (bus1.out_data !== 8'(exp1) || bus1.out_keep !== 1'b1) bad1 <= bad1 + 1;
      run1 <= run1 + 1;
      if (run1 + 1 > max1) max1 <= run1 + 1;
    end else begin
      run1 <= 0;
    end
  end

  task automatic wait_drain(input string nm);
    for (int i = 0; i < 200 && rd_ptr != wr_ptr; i++) @(negedge clk);
    chk(nm, 64'(rd_ptr == wr_ptr), 64'd1);
  endtask

  typedef struct {
    int          nwords;
    logic [7:0]  first;
    logic        do_flush;
    int          nout;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [3:0]  k0;
    logic [3:0]  k1;
  } vec_t;

  vec_t vecs [0:5];

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    int base;
    int p0;
    logic [31:0] exp_d;
    logic [3:0]  exp_k;
    logic [31:0] bp_exp [0:3];

    vecs[0] = '{8, 8'h01, 1'b0, 2, 32'h04030201, 32'h08070605, 4'hF, 4'hF};
    vecs[1] = '{3, 8'hA1, 1'b1, 1, 32'h00A3A2A1, 32'h0,        4'h7, 4'h0};
    vecs[2] = '{4, 8'hB1, 1'b0, 1, 32'hB4B3B2B1, 32'h0,        4'hF, 4'h0};
    vecs[3] = '{1, 8'hC1, 1'b1, 1, 32'h000000C1, 32'h0,        4'h1, 4'h0};
    vecs[4] = '{5, 8'hD1, 1'b1, 2, 32'hD4D3D2D1, 32'h000000D5, 4'hF, 4'h1};
    vecs[5] = '{4, 8'hE1, 1'b1, 1, 32'hE4E3E2E1, 32'h0,        4'hF, 4'h0};
    bp_exp[0] = 32'h14131211;
    bp_exp[1] = 32'h18171615;
    bp_exp[2] = 32'h1C1B1A19;
    bp_exp[3] = 32'h201F1E1D;

    rst           = 1'b1;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;

    // Reset state; a word queued during reset must not be popped or survive.
    @(negedge clk);
    push(8'h99);
    #1;
    chk("rst_pop", 64'(bus.pop), 64'd0);
    chk("rst_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_data", 64'(bus.out_data), 64'd0);
    chk("rst_keep", 64'(bus.out_keep), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      base = rx_n;
      for (int k = 0; k < vecs[v].nwords; k++) push(vecs[v].first + 8'(k));
      wait_drain($sformatf("v%0d_drain", v));
      repeat (3) @(negedge clk);
      if (vecs[v].do_flush) begin
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
      end
      repeat (6) @(negedge clk);
      chk($sformatf("v%0d_poprun", v), 64'(last_run), 64'(vecs[v].nwords));
      chk($sformatf("v%0d_count", v), 64'(rx_n - base), 64'(vecs[v].nout));
      for (int j = 0; j < vecs[v].nout; j++) begin
        exp_d = (j == 0) ? vecs[v].d0 : vecs[v].d1;
        exp_k = (j == 0) ? vecs[v].k0 : vecs[v].k1;
        chk($sformatf("v%0d_data%0d", v, j), 64'(rx_data[base + j]), 64'(exp_d));
        chk($sformatf("v%0d_keep%0d", v, j), 64'(rx_keep[base + j]), 64'(exp_k));
      end
    end

    // Back-pressure: two words buffered plus three lanes packed, then pops stop.
    bus.out_ready = 1'b0;
    base = rx_n;
    p0   = pop_total;
    for (int k = 1; k <= 16; k++) push(8'h10 + 8'(k));
    repeat (25) @(negedge clk);
    chk("bp_pops", 64'(pop_total - p0), 64'd11);
    chk("bp_pop_low", 64'(bus.pop), 64'd0);
    chk("bp_valid", 64'(bus.out_valid), 64'd1);
    chk("bp_head", 64'(bus.out_data), 64'h14131211);
    chk("bp_none_out", 64'(rx_n - base), 64'd0);
    bus.out_ready = 1'b1;
    wait_drain("bp_drain");
    repeat (8) @(negedge clk);
    chk("bp_count", 64'(rx_n - base), 64'd4);
    for (int j = 0; j < 4; j++) begin
      chk($sformatf("bp_data%0d", j), 64'(rx_data[base + j]), 64'(bp_exp[j]));
      chk($sformatf("bp_keep%0d", j), 64'(rx_keep[base + j]), 64'hF);
    end

    // Empty toggling every cycle.
    base = rx_n;
    for (int k = 1; k <= 8; k++) push(8'h30 + 8'(k));
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      empty_force = ~empty_force;
    end
    empty_force = 1'b0;
    wait_drain("tg_drain");
    repeat (6) @(negedge clk);
    chk("tg_count", 64'(rx_n - base), 64'd2);
    chk("tg_data0", 64'(rx_data[base]), 64'h34333231);
    chk("tg_data1", 64'(rx_data[base + 1]), 64'h38373635);

    // Reset with one word buffered and two lanes packed.
    bus.out_ready = 1'b0;
    for (int k = 1; k <= 6; k++) push(8'h40 + 8'(k));
    wait_drain("rm_drain");
    repeat (3) @(negedge clk);
    chk("rm_pre_valid", 64'(bus.out_valid), 64'd1);
    rst = 1'b1;
    push(8'h77);
    #1;
    chk("rm_pop_in_rst", 64'(bus.pop), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rm_valid", 64'(bus.out_valid), 64'd0);
    chk("rm_pop", 64'(bus.pop), 64'd0);
    bus.out_ready = 1'b1;
    base = rx_n;
    for (int k = 1; k <= 4; k++) push(8'h50 + 8'(k));
    wait_drain("rm_refill");
    repeat (6) @(negedge clk);
    chk("rm_count", 64'(rx_n - base), 64'd1);
    chk("rm_data", 64'(rx_data[base]), 64'h54535251);
    chk("rm_keep", 64'(rx_keep[base]), 64'hF);

    // RATIO=1 streaming.
    @(negedge clk);
    en1 = 1'b1;
    repeat (20) @(negedge clk);
    en1 = 1'b0;
    repeat (5) @(negedge clk);
    chk("r1_count", 64'(n1), 64'd20);
    chk("r1_bad", 64'(bad1), 64'd0);
    chk("r1_run", 64'(max1), 64'd20);

    chk("pop_while_empty", 64'(pe_viol), 64'd0);
    chk("hold_stable", 64'(stab_viol), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/async_fifo_rd_packer.md
Name: async_fifo_rd_packer

Overview:
- Read-side consumer of the asynchronous FIFO, in the rdclk domain.
- Drives the FIFO read port (pop/empty/rddata).
- Packs RATIO consecutive DWIDTH-bit words into one wide word.
- Presents packed words on a valid/ready stream through a 2-entry output buffer, so it sustains one pop per cycle under back-pressure-free operation.
- A flush pulse forces out a partially packed word, marked by a keep mask.

Parameters:
- DWIDTH, 8: FIFO word width in bits; must match the FIFO instance.
- RATIO, 4: FIFO words per output word; legal range 1..16.

Ports:
- rdclk  input  1  read-domain clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- pop  output  1  FIFO read strobe.
- empty  input  1  FIFO empty flag.
- rddata  input  DWIDTH  FIFO read data; valid the cycle after pop (registered read).
- flush  input  1  single-cycle request to emit the partial word.
- out_valid  output  1  packed word available.
- out_ready  input  1  downstream accepts the word.
- out_data  output  DWIDTH*RATIO  packed word; first-popped word in bits [DWIDTH-1:0].
- out_keep  output  RATIO  per-lane valid mask; all ones for full words.

Behaviour:
- Interface: one clock (rdclk); reset is synchronous and active-high.
- Reset values:
  - pop=0, out_valid=0, out_data=0, out_keep=0.
  - Lane index, in-flight flag, flush-pending flag and output buffer count all cleared.
  - Data returning for a pop issued in the reset cycle is discarded; the FIFO is reset on the same reset.
- Pop issue:
  - pop is combinational and asserted iff !empty && !flush_pending && slot_ok.
  - pop is never asserted while empty=1.
- slot_ok:
  - Define cnt_eff = obuf_cnt - (out_valid && out_ready) + inflight_completes + issue_completes.
  - inflight_completes = 1 if the pop issued last cycle fills lane RATIO-1.
  - issue_completes = 1 if this pop would fill lane RATIO-1.
  - slot_ok requires cnt_eff <= 2. This guarantees the output buffer never overflows.
- Return path:
  - One cycle after pop, rddata is written into lane `lane` of the pack register and lane increments.
  - When lane RATIO-1 is written, the full word with keep all ones enters the output buffer in that same edge, and lane wraps to 0.
  - RATIO=1: every pop produces one output word.
- Output buffer:
  - 2-entry FIFO, strictly in order.
  - out_valid = (obuf_cnt != 0).
  - Transfer occurs on out_valid && out_ready.
  - out_data and out_keep hold stable while out_valid && !out_ready.
  - A simultaneous enqueue and dequeue leaves the count unchanged.
- Flush:
  - flush sets flush_pending; pops stop the same cycle.
  - Once no pop is in flight and the output buffer has a free slot:
    - if lane > 0, emit the pack register with out_keep = (1<<lane)-1, unfilled lanes zero, and set lane=0;
    - if lane == 0, emit nothing.
  - flush_pending then clears.
  - flush asserted while flush_pending=1 is ignored.
  - A flush arriving in the same cycle a word completes does not emit an empty word.
- Throughput: with out_ready held at 1 and the FIFO non-empty, pop is high every cycle and one output word is produced every RATIO cycles. Latency from the first pop to out_valid is RATIO+1 cycles.

Test Plan:
- Reset, then write 0x01..0x08 into the FIFO, out_ready=1, RATIO=4 -> pop high 8 consecutive cycles; out_data=0x04030201 then 0x08070605; out_keep=4'hF on both.
- Hold out_ready=0 while 16 words are queued -> exactly 2 words buffered, pop drops after 8 pops plus in-flight; release out_ready -> remaining words emitted in order with no loss or duplication.
- Write 3 words 0xA1,0xA2,0xA3, then flush -> one word out_data=0x00A3A2A1, out_keep=4'h7; lane returns to 0; next 4 words form a full word.
- FIFO empty toggling every cycle -> pop never high while empty=1; packed output matches the write order.
- Assert reset mid-packing with 2 lanes filled and 1 word in the output buffer -> next cycle out_valid=0 and pop=0; after refill, the first output word contains only post-reset data.
- RATIO=1, continuous data, out_ready=1 -> one output word per cycle at steady state; out_keep=1'b1.
